// File: rtl/lsu_load_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_load_ctrl
//   LSU-side load sequencer. Takes one strided load command from decode,
//   issues a single AR request to the AXI read interface block, then streams
//   every returned R beat into the local load buffer at consecutive addresses.
//   Completion is flagged by a one-cycle ld_done pulse together with a sticky
//   ld_err that holds until the next command is accepted.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_*                 load command (valid/ready handshake)
//   lsu_axi_ar*           read request towards the AXI read interface
//   axi_lsu_arrdy         read interface ready for a request
//   axi_lsu_r*            returned beats from the AXI read interface
//   lsu_axi_rrdy          beat accept (follows buf_wrdy while receiving)
//   buf_wrdy              load buffer can take a write this cycle
//   buf_wen/waddr/wdata   load buffer write port
//   ld_done, ld_err       completion pulse and sticky error status
// -----------------------------------------------------------------------------
module lsu_load_ctrl #(
    parameter int BUF_AW = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [7:0]        cmd_id,
    input  logic [9:0]        cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic [2:0]        cmd_str,
    input  logic [BUF_AW-1:0] cmd_dst,

    output logic [7:0]        lsu_axi_arid,
    output logic [9:0]        lsu_axi_araddr,
    output logic [7:0]        lsu_axi_arlen,
    output logic [2:0]        lsu_axi_arsize,
    output logic [1:0]        lsu_axi_arburst,
    output logic [2:0]        lsu_axi_arstr,
    output logic              lsu_axi_arvld,
    input  logic              axi_lsu_arrdy,

    input  logic [7:0]        axi_lsu_rid,
    input  logic [DATA_W-1:0] axi_lsu_rdata,
    input  logic [1:0]        axi_lsu_rresp,
    input  logic              axi_lsu_rlast,
    input  logic              axi_lsu_rvld,
    output logic              lsu_axi_rrdy,

    input  logic              buf_wrdy,
    output logic              buf_wen,
    output logic [BUF_AW-1:0] buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,

    output logic              ld_done,
    output logic              ld_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    // Registered copy of the accepted command; drives the AR channel so the
    // request stays stable while the read interface stalls.
    typedef struct packed {
        logic [7:0]        id;
        logic [9:0]        addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [2:0]        str;
        logic [BUF_AW-1:0] dst;
    } ld_cmd_t;

    state_t      state_q;
    ld_cmd_t     cmd_q;
    logic [10:0] exp_beats_q;
    logic [10:0] beat_cnt_q;
    logic        err_q;
    logic        ld_err_q;

    // Request count selected by size: one request for small sizes, two or
    // four for the wide ones. Total beats fit in 11 bits (4 * 256 max).
    logic [2:0]  nreq;
    logic [10:0] exp_beats_d;

    always_comb begin
        nreq = 3'd1;
        if (cmd_size[2])
            nreq = cmd_size[0] ? 3'd4 : 3'd2;
        exp_beats_d = 11'(nreq) * (11'(cmd_len) + 11'd1);
    end

    logic beat_acc;
    logic beat_err;
    logic last_beat;

    assign beat_acc  = (state_q == RECV) && axi_lsu_rvld && buf_wrdy;
    assign beat_err  = (axi_lsu_rresp != 2'b00);
    // rlast is ignored on purpose: a multi-request load sees several rlast
    // beats, so only the beat count decides when the load is complete.
    assign last_beat = beat_acc && ((beat_cnt_q + 11'd1) == exp_beats_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            exp_beats_q <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_vld) begin
                        cmd_q.id    <= cmd_id;
                        cmd_q.addr  <= cmd_addr;
                        cmd_q.len   <= cmd_len;
                        cmd_q.size  <= cmd_size;
                        cmd_q.burst <= cmd_burst;
                        cmd_q.str   <= cmd_str;
                        cmd_q.dst   <= cmd_dst;
                        exp_beats_q <= exp_beats_d;
                        beat_cnt_q  <= '0;
                        err_q       <= 1'b0;
                        ld_err_q    <= 1'b0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (axi_lsu_arrdy)
                        state_q <= RECV;
                end
                RECV: begin
                    if (beat_acc) begin
                        beat_cnt_q <= beat_cnt_q + 11'd1;
                        if (beat_err)
                            err_q <= 1'b1;
                        if (last_beat) begin
                            // Fold in the final beat's response so an error on
                            // the last beat is still reported with ld_done.
                            ld_err_q <= err_q | beat_err;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Control outputs decode directly from the state register, so they carry
    // no combinational path from inputs (except the R-channel pass-through).
    assign cmd_rdy         = (state_q == IDLE);
    assign lsu_axi_arvld   = (state_q == REQ);
    assign ld_done         = (state_q == DONE);
    assign ld_err          = ld_err_q;

    assign lsu_axi_arid    = cmd_q.id;
    assign lsu_axi_araddr  = cmd_q.addr;
    assign lsu_axi_arlen   = cmd_q.len;
    assign lsu_axi_arsize  = cmd_q.size;
    assign lsu_axi_arburst = cmd_q.burst;
    assign lsu_axi_arstr   = cmd_q.str;

    // While receiving, beat accept follows buffer readiness so a stalled
    // buffer leaves the beat held upstream.
    assign lsu_axi_rrdy    = (state_q == RECV) && buf_wrdy;
    assign buf_wen         = beat_acc;
    // Buffer address wraps modulo 2^BUF_AW by truncation.
    assign buf_waddr       = beat_acc ? (cmd_q.dst + BUF_AW'(beat_cnt_q)) : '0;
    assign buf_wdata       = beat_acc ? axi_lsu_rdata : '0;

    // rid and rlast carry no control meaning here.
    logic unused_r;
    assign unused_r = ^{axi_lsu_rid, axi_lsu_rlast};

endmodule
